// File: rtl/gamepad_ctrl.sv
// Gamepad controller: 2-FF key synchronizers, per-key debounce, pending-mask
// arbiter into a show-ahead event FIFO, and two registered blinking LED drivers.
module gamepad_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int BLINK_DIV       = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       key_right_i,
  input  logic       key_left_i,
  input  logic       key_a_i,
  input  logic       key_b_i,
  output logic [5:0] keys_o,
  output logic       evt_valid_o,
  input  logic       evt_ready_i,
  output logic [2:0] evt_key_o,
  output logic       evt_press_o,
  output logic       overflow_o,
  input  logic       ovf_clr_i,
  input  logic [1:0] led1_mode_i,
  input  logic [1:0] led2_mode_i,
  output logic       led1_o,
  output logic       led2_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [5:0]    raw_keys;
  logic [5:0]    sync_meta_reg;
  logic [5:0]    sync_reg;
  logic [5:0]    stable_reg;
  logic [CW-1:0] cnt_reg [6];
  logic [5:0]    commit;

  assign raw_keys = {key_b_i, key_a_i, key_left_i, key_right_i, key_down_i, key_up_i};
  assign keys_o   = stable_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta_reg <= '0;
      sync_reg      <= '0;
    end else begin
      sync_meta_reg <= raw_keys;
      sync_reg      <= sync_meta_reg;
    end
  end

  // The counter reaching DEBOUNCE_CYCLES is folded into the edge where it
  // would have been written, so commit is decoded from the pre-increment value.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_commit
      assign commit[gi] = (sync_reg[gi] != stable_reg[gi]) && (cnt_reg[gi] == CNT_LAST);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_reg <= '0;
      for (int i = 0; i < 6; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync_reg[i] == stable_reg[i]) begin
          cnt_reg[i] <= '0;
        end else if (commit[i]) begin
          stable_reg[i] <= sync_reg[i];
          cnt_reg[i]    <= '0;
        end else begin
          cnt_reg[i] <= cnt_reg[i] + CW'(1);
        end
      end
    end
  end

  logic [5:0]  pending_reg, pending_next;
  logic [2:0]  sel;
  logic        push, pop, full, empty, collapse;
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [3:0]  fifo_mem [FIFO_DEPTH];
  logic [3:0]  head;
  logic        overflow_reg;

  always_comb begin
    sel = '0;
    for (int i = 5; i >= 0; i--) begin
      if (pending_reg[i]) sel = 3'(i);
    end
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = !empty && evt_ready_i;
  assign push  = (|pending_reg) && (!full || pop);

  // A commit racing its own push keeps the bit set: the pushed event carries
  // the old level, the new level still needs its own event.
  always_comb begin
    pending_next = pending_reg;
    collapse     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (commit[i]) begin
        if (push && (sel == 3'(i))) begin
          pending_next[i] = 1'b1;
        end else if (pending_reg[i]) begin
          pending_next[i] = 1'b0;
          collapse        = 1'b1;
        end else begin
          pending_next[i] = 1'b1;
        end
      end else if (push && (sel == 3'(i))) begin
        pending_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (collapse)       overflow_reg <= 1'b1;
      else if (ovf_clr_i) overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= {sel, stable_reg[sel]};
  end

  // Storage is not reset, so the head is masked while the queue is empty.
  assign head        = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign evt_valid_o = !empty;
  assign evt_key_o   = empty ? 3'd0 : head[3:1];
  assign evt_press_o = !empty && head[0];
  assign overflow_o  = overflow_reg;

  logic [BLINK_DIV-1:0] blink_cnt_reg;
  logic                 led1_reg, led2_reg;

  function automatic logic led_drive(input logic [1:0] mode, input logic slow,
                                     input logic fast);
    case (mode)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return slow;
      default: return fast;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blink_cnt_reg <= '0;
      led1_reg      <= 1'b0;
      led2_reg      <= 1'b0;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_DIV'(1);
      led1_reg <= led_drive(led1_mode_i, blink_cnt_reg[BLINK_DIV-1], blink_cnt_reg[BLINK_DIV-3]);
      led2_reg <= led_drive(led2_mode_i, blink_cnt_reg[BLINK_DIV-1], blink_cnt_reg[BLINK_DIV-3]);
    end
  end

  assign led1_o = led1_reg;
  assign led2_o = led2_reg;

endmodule

// File: tb/tb_gamepad_ctrl.sv
// Scoreboard bench for gamepad_ctrl: stimulus queues expected events, a negedge
// monitor pops and compares each accepted event; direct checks cover timing.
module tb_gamepad_ctrl;
  localparam int DB = 4;
  localparam int FD = 4;
  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_up, key_down, key_right, key_left, key_a, key_b;
  logic [5:0] keys;
  logic       evt_valid, evt_ready, evt_press, overflow, ovf_clr;
  logic [2:0] evt_key;
  logic [1:0] led1_mode, led2_mode;
  logic       led1, led2;

  gamepad_ctrl #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD), .BLINK_DIV(BD)) dut (
    .clk_i(clk), .rst_i(rst),
    .key_up_i(key_up), .key_down_i(key_down), .key_right_i(key_right),
    .key_left_i(key_left), .key_a_i(key_a), .key_b_i(key_b),
    .keys_o(keys), .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
    .evt_key_o(evt_key), .evt_press_o(evt_press),
    .overflow_o(overflow), .ovf_clr_i(ovf_clr),
    .led1_mode_i(led1_mode), .led2_mode_i(led2_mode),
    .led1_o(led1), .led2_o(led2)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [3:0] exp_q [$];
  int         acc_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input int key, input int press);
    exp_q.push_back({3'(key), 1'(press)});
  endtask

  task automatic set_keys(input logic [5:0] k);
    {key_b, key_a, key_left, key_right, key_down, key_up} = k;
  endtask

  // Monitor: an accept is seen at the negedge before the popping posedge.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      acc_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got key %0d press %0d, expected none (t=%0t)",
                 evt_key, evt_press, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("event", {evt_key, evt_press}, e);
        $display("event key=%0d press=%0d expected key=%0d press=%0d",
                 evt_key, evt_press, e[3:1], e[0]);
      end
    end
  end

  initial begin
    int seen, bad1, bad2, tog1, tog2, run1, run2;
    logic p1, p2;
    rst = 1'b1; set_keys(6'b0); evt_ready = 1'b0; ovf_clr = 1'b0;
    led1_mode = 2'b00; led2_mode = 2'b00;
    tick(2);
    check("reset_keys", keys, 0);
    check("reset_valid", evt_valid, 0);
    check("reset_head", {evt_key, evt_press}, 0);
    check("reset_ovf", overflow, 0);
    check("reset_leds", {led1, led2}, 0);
    rst = 1'b0;
    tick(2);

    // Single press: first sampled at edge N, keys_o rises after edge N+5.
    evt_ready = 1'b1;
    acc_log.delete();
    expect_evt(4, 1);
    set_keys(6'b010000);
    tick(5);
    check("a_latency_early", keys[4], 0);
    tick(1);
    check("a_latency_edge", keys[4], 1);
    tick(6);
    check("a_event_count", acc_log.size(), 1);
    check("a_valid_drop", evt_valid, 0);
    expect_evt(4, 0);
    set_keys(6'b0);
    tick(10);

    // 3-cycle glitch must be filtered out.
    acc_log.delete();
    set_keys(6'b000001);
    tick(3);
    set_keys(6'b0);
    seen = 0;
    repeat (12) begin
      tick(1);
      if (keys[0]) seen = 1;
    end
    check("glitch_keys", seen, 0);
    check("glitch_events", acc_log.size(), 0);

    // Simultaneous commit: ascending IDs on consecutive cycles.
    acc_log.delete();
    expect_evt(0, 1); expect_evt(3, 1); expect_evt(5, 1);
    set_keys(6'b101001);
    tick(12);
    check("multi_count", acc_log.size(), 3);
    if (acc_log.size() == 3) check("multi_consecutive", acc_log[2] - acc_log[0], 2);
    expect_evt(0, 0); expect_evt(3, 0); expect_evt(5, 0);
    set_keys(6'b0);
    tick(12);

    // Backpressure, collapse and overflow behaviour.
    evt_ready = 1'b0;
    expect_evt(0, 1); expect_evt(1, 1); expect_evt(2, 1); expect_evt(0, 0);
    set_keys(6'b000111);
    tick(10);
    check("bp_head_press", {evt_key, evt_press}, 1);
    set_keys(6'b0);
    tick(10);
    check("bp_head_hold", {evt_key, evt_press}, 1);
    check("bp_valid", evt_valid, 1);
    check("bp_no_ovf", overflow, 0);
    set_keys(6'b000010);
    tick(8);
    check("collapse_ovf", overflow, 1);
    check("collapse_keys", keys, 2);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check("ovf_clear", overflow, 0);
    set_keys(6'b000110);
    tick(5);
    check("ovf_pre_commit", overflow, 0);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    evt_ready = 1'b1;
    tick(10);
    check("bp_drained", exp_q.size(), 0);
    check("bp_valid_after", evt_valid, 0);
    expect_evt(1, 0); expect_evt(2, 0);
    set_keys(6'b0);
    tick(12);

    // LEDs.
    led1_mode = 2'b01; led2_mode = 2'b00;
    tick(2);
    check("led_on", led1, 1);
    check("led_off", led2, 0);
    led1_mode = 2'b10; led2_mode = 2'b11;
    tick(2);
    p1 = led1; p2 = led2; run1 = 0; run2 = 0;
    bad1 = 0; bad2 = 0; tog1 = 0; tog2 = 0;
    repeat (40) begin
      tick(1);
      run1++; run2++;
      if (led1 != p1) begin
        if (tog1 > 0 && run1 != 8) bad1++;
        tog1++; run1 = 0; p1 = led1;
      end
      if (led2 != p2) begin
        if (tog2 > 0 && run2 != 2) bad2++;
        tog2++; run2 = 0; p2 = led2;
      end
    end
    check("slow_period", bad1, 0);
    check("slow_toggles", int'(tog1 >= 4), 1);
    check("fast_period", bad2, 0);
    check("fast_toggles", int'(tog2 >= 18), 1);

    // Asynchronous reset with queued events and a debounce in flight.
    led1_mode = 2'b01; led2_mode = 2'b00;
    evt_ready = 1'b0;
    set_keys(6'b000011);
    tick(9);
    set_keys(6'b010011);
    tick(2);
    check("prereset_valid", evt_valid, 1);
    check("prereset_led", led1, 1);
    #2 rst = 1'b1;
    #1;
    check("async_keys", keys, 0);
    check("async_valid", evt_valid, 0);
    check("async_led", led1, 0);
    set_keys(6'b0);
    led1_mode = 2'b00;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    evt_ready = 1'b1;
    tick(15);
    check("post_reset_valid", evt_valid, 0);
    check("post_reset_keys", keys, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
